alu_seq: RTL and testbench

//   Parametrised, handshaked ALU; next generation of the 4-bit combinational ALU.

---
 rtl/alu_seq.sv | 155 +++++++++++++++
 tb/tb_alu_seq.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked, registered ALU: PASS/ADD/AND/NOT/SUB/OR/XOR in one cycle, MUL as a shift-add sequence.
// Define ALU_MUL_EN to build the multiplier; otherwise opcode 111 reports ill=1 in one cycle.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             ill
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t           state_q;
  logic             started_q;
  logic [WIDTH-1:0] f_q;
  logic             cout_q;
  logic             ovf_q;
  logic             ill_q;

  logic [WIDTH-1:0] f_d;
  logic             cout_d;
  logic             ovf_d;
  logic             ill_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             accept;
  logic             is_mul;

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  assign is_mul = (sel == 3'b111);
`else
  assign is_mul = 1'b0;
`endif

  // started_q keeps in_ready low until the first clock edge after reset release.
  assign in_ready  = started_q & ((state_q == IDLE) | ((state_q == HOLD) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == HOLD);
  assign f         = f_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign ill       = ill_q;
  assign zero      = (f_q == '0);

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff   = {1'b0, a} - {1'b0, b};
    f_d    = '0;
    cout_d = 1'b0;
    ovf_d  = 1'b0;
    ill_d  = 1'b0;
    case (sel)
      3'b000: f_d = a;
      3'b001: begin
        f_d    = sum[WIDTH-1:0];
        cout_d = sum[WIDTH];
        ovf_d  = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      3'b010: f_d = a & b;
      3'b011: f_d = ~a;
      3'b100: begin
        f_d    = diff[WIDTH-1:0];
        cout_d = diff[WIDTH];
        ovf_d  = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      3'b101: f_d = a | b;
      3'b110: f_d = a ^ b;
      default: begin
`ifdef ALU_MUL_EN
        ill_d = 1'b0;
`else
        ill_d = 1'b1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      f_q       <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ill_q     <= 1'b0;
`ifdef ALU_MUL_EN
      cnt_q     <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
`endif
    end else begin
      started_q <= 1'b1;
      case (state_q)
        IDLE, HOLD: begin
          if (accept) begin
            if (is_mul) begin
`ifdef ALU_MUL_EN
              state_q  <= BUSY;
              cnt_q    <= CW'(WIDTH);
              acc_q    <= '0;
              mcand_q  <= {{WIDTH{1'b0}}, a};
              mplier_q <= b;
`endif
            end else begin
              state_q <= HOLD;
              f_q     <= f_d;
              cout_q  <= cout_d;
              ovf_q   <= ovf_d;
              ill_q   <= ill_d;
            end
          end else if (state_q == HOLD && out_ready) begin
            state_q <= IDLE;
          end
        end
`ifdef ALU_MUL_EN
        BUSY: begin
          // WIDTH add/shift steps, then one cycle to publish the product.
          if (cnt_q != '0) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
          end else begin
            state_q <= HOLD;
            f_q     <= acc_q[WIDTH-1:0];
            cout_q  <= |acc_q[2*WIDTH-1:WIDTH];
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4; MUL checks run when ALU_MUL_EN is defined.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] sel;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] f;
  logic       cout;
  logic       ovf;
  logic       zero;
  logic       ill;

  int checks = 0;
  int errors = 0;
  int n;
  int seen;

  alu_seq #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .cin(cin), .out_valid(out_valid),
    .out_ready(out_ready), .f(f), .cout(cout), .ovf(ovf), .zero(zero), .ill(ill)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [3:0] ef, input logic ec,
                           input logic eo, input logic ez, input logic ei);
    $display("txn %s: f=%b cout=%b ovf=%b zero=%b ill=%b out_valid=%b", tag, f, cout, ovf, zero, ill, out_valid);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".f"},     32'(f),         32'(ef));
    check({tag, ".cout"},  32'(cout),      32'(ec));
    check({tag, ".ovf"},   32'(ovf),       32'(eo));
    check({tag, ".zero"},  32'(zero),      32'(ez));
    check({tag, ".ill"},   32'(ill),       32'(ei));
  endtask

  task automatic drive(input logic [2:0] s, input logic [3:0] av, input logic [3:0] bv, input logic c);
    in_valid = 1'b1;
    sel = s;
    a = av;
    b = bv;
    cin = c;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel = 3'd0; a = 4'd0; b = 4'd0; cin = 1'b0; out_ready = 1'b1;
    #12;
    check("rst.in_ready",  32'(in_ready),  32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.f",         32'(f),         32'd0);
    check("rst.zero",      32'(zero),      32'd1);
    check("rst.flags",     32'({cout, ovf, ill}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst.in_ready", 32'(in_ready), 32'd1);

    // Back-to-back beats with out_ready held high: one result per clock.
    drive(3'b001, 4'b0111, 4'b0001, 1'b0); step(); check_res("add_ovf",   4'b1000, 0, 1, 0, 0);
    check("b2b.in_ready", 32'(in_ready), 32'd1);
    drive(3'b001, 4'b1111, 4'b0001, 1'b0); step(); check_res("add_carry", 4'b0000, 1, 0, 1, 0);
    drive(3'b001, 4'b0011, 4'b0100, 1'b1); step(); check_res("add_cin",   4'b1000, 0, 1, 0, 0);
    drive(3'b100, 4'b0010, 4'b0011, 1'b0); step(); check_res("sub_borrow",4'b1111, 1, 0, 0, 0);
    drive(3'b100, 4'b1000, 4'b0001, 1'b0); step(); check_res("sub_ovf",   4'b0111, 0, 1, 0, 0);
    drive(3'b000, 4'b1010, 4'b0101, 1'b1); step(); check_res("pass",      4'b1010, 0, 0, 0, 0);
    check("b2b.in_ready2", 32'(in_ready), 32'd1);
    drive(3'b010, 4'b1100, 4'b1010, 1'b0); step(); check_res("and",       4'b1000, 0, 0, 0, 0);
    drive(3'b011, 4'b1100, 4'b0000, 1'b0); step(); check_res("not",       4'b0011, 0, 0, 0, 0);
    drive(3'b101, 4'b0101, 4'b1010, 1'b0); step(); check_res("or",        4'b1111, 0, 0, 0, 0);
    drive(3'b110, 4'b1100, 4'b1010, 1'b0); step(); check_res("xor",       4'b0110, 0, 0, 0, 0);
    check("b2b.in_ready3", 32'(in_ready), 32'd1);

    // Stall in HOLD: result frozen, nothing accepted while inputs wander.
    out_ready = 1'b0;
    drive(3'b001, 4'b0001, 4'b0010, 1'b0);
    #1;
    check("stall.in_ready_comb", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      a = 4'(i);
      step();
      $display("txn stall%0d: f=%b in_ready=%b out_valid=%b", i, f, in_ready, out_valid);
      check("stall.f",        32'(f),         32'b0110);
      check("stall.valid",    32'(out_valid), 32'd1);
      check("stall.in_ready", 32'(in_ready),  32'd0);
    end
    a = 4'b0001;
    out_ready = 1'b1;
    #1;
    check("unstall.in_ready", 32'(in_ready), 32'd1);
    step(); check_res("after_stall", 4'b0011, 0, 0, 0, 0);
    in_valid = 1'b0;
    step();
    check("idle.out_valid", 32'(out_valid), 32'd0);
    check("idle.in_ready",  32'(in_ready),  32'd1);

`ifdef ALU_MUL_EN
    drive(3'b111, 4'b0101, 4'b0011, 1'b0); step();
    in_valid = 1'b0; sel = 3'b000; a = 4'd0; b = 4'd0;
    check("mul.busy_in_ready", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check("mul1.latency", 32'(n), 32'd5);
    check_res("mul_5x3", 4'b1111, 0, 0, 0, 0);
    drive(3'b111, 4'b1111, 4'b1111, 1'b0); step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check("mul2.latency", 32'(n), 32'd5);
    check_res("mul_15x15", 4'b0001, 1, 0, 0, 0);
    step();
    drive(3'b111, 4'b0101, 4'b0011, 1'b0); step();
    in_valid = 1'b0;
    step(); step();
`else
    drive(3'b111, 4'b0101, 4'b0011, 1'b0); step();
    check_res("ill_op", 4'b0000, 0, 0, 1, 1);
    drive(3'b001, 4'b0111, 4'b0001, 1'b0); step();
    check_res("ill_clear", 4'b1000, 0, 1, 0, 0);
    in_valid = 1'b0; out_ready = 1'b0;
    step();
`endif
    // Asynchronous reset mid-operation: outputs clear at once and nothing is delivered later.
    rst_n = 1'b0;
    #1;
    $display("txn abort: f=%b out_valid=%b in_ready=%b", f, out_valid, in_ready);
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.f",         32'(f),         32'd0);
    check("abort.zero",      32'(zero),      32'd1);
    check("abort.flags",     32'({cout, ovf, ill}), 32'd0);
    check("abort.in_ready",  32'(in_ready),  32'd0);
    out_ready = 1'b1;
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("abort.no_result", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
